// File: rtl/conv_pkg.sv
// conv_pkg: shared geometry, config width and scheduler state encoding for the conv layer
package conv_pkg;
  localparam int KSIZE    = 4;
  localparam int FMAP_DIM = 64;
  localparam int LANES    = 8;
  localparam int MAX_CH   = 32;
  localparam int WA_W     = 14;
  localparam int FA_W     = 17;
  localparam int CFG_W    = 2;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_F, WAIT_PE, NEXT_GRP, DONE} sched_state_t;
endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: outer/inner counter pair advancing on accepted beats, wrapping at full count
module conv_addr_gen #(
  parameter int OW = 3,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [OW-1:0] outer,
  output logic [IW-1:0] inner,
  output logic          last
);
  always_ff @(posedge clk)
    if (!rst_n) begin
      outer <= '0;
      inner <= '0;
    end else if (adv) begin
      inner <= inner + 1'b1;
      if (&inner) outer <= outer + 1'b1;
    end
  assign last = &outer && &inner;
endmodule

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler: walks co/ci group pairs of one CONV layer, streaming weights then ifmap per pair
module conv_layer_scheduler
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_start_conv,
  input  logic [2:0]      in_cfg_ci,
  input  logic [2:0]      in_cfg_co,
  output logic [WA_W-1:0] wgt_addr,
  output logic            wgt_valid,
  output logic [FA_W-1:0] fmap_addr,
  output logic            fmap_valid,
  input  logic            rd_ready,
  output logic [1:0]      ci_grp,
  output logic [1:0]      co_grp,
  output logic            acc_clear,
  output logic            acc_last,
  input  logic            pe_done,
  output logic            out_end_conv
);
  localparam int KW = $clog2(LANES);
  localparam int VW = $clog2(KSIZE * KSIZE);
  localparam int PW = $clog2(FMAP_DIM);
  sched_state_t state, state_nx;
  logic [CFG_W-1:0] cfg_ci, cfg_co;
  logic [KW-1:0] kk;
  logic [VW-1:0] v;
  logic [PW-1:0] col, row;
  logic w_last, f_last, busy, ci_wrap, grp_last;
  logic cfg_unused;
  // cfg values 4..7 alias onto 0..3, so bit 2 is dropped
  assign cfg_unused = in_cfg_ci[2] ^ in_cfg_co[2];
  conv_addr_gen #(.OW(KW), .IW(VW)) u_wgt (
    .clk(clk), .rst_n(rst_n), .adv(wgt_valid && rd_ready),
    .outer(kk), .inner(v), .last(w_last)
  );
  conv_addr_gen #(.OW(PW), .IW(PW)) u_fmap (
    .clk(clk), .rst_n(rst_n), .adv(fmap_valid && rd_ready),
    .outer(col), .inner(row), .last(f_last)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state  <= IDLE;
      cfg_ci <= '0;
      cfg_co <= '0;
      ci_grp <= '0;
      co_grp <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_start_conv) begin
        cfg_ci <= in_cfg_ci[CFG_W-1:0];
        cfg_co <= in_cfg_co[CFG_W-1:0];
        ci_grp <= '0;
        co_grp <= '0;
      end
      if (state == NEXT_GRP) begin
        ci_grp <= ci_wrap ? '0 : ci_grp + 1'b1;
        co_grp <= grp_last ? '0 : co_grp + 2'(ci_wrap);
      end
    end
  always_comb begin
    ci_wrap      = ci_grp == cfg_ci;
    grp_last     = ci_wrap && co_grp == cfg_co;
    busy         = state inside {LOAD_W, LOAD_F, WAIT_PE};
    wgt_valid    = state == LOAD_W;
    fmap_valid   = state == LOAD_F;
    acc_clear    = busy && ci_grp == '0;
    acc_last     = busy && ci_wrap;
    out_end_conv = state == DONE;
    wgt_addr     = wgt_valid ? WA_W'(((co_grp * LANES + kk) * MAX_CH + ci_grp * LANES) * KSIZE * KSIZE + v) : '0;
    fmap_addr    = fmap_valid ? FA_W'(ci_grp * LANES * FMAP_DIM * FMAP_DIM + row * FMAP_DIM + col) : '0;
    state_nx     = state;
    case (state)
      IDLE:     state_nx = in_start_conv ? LOAD_W : IDLE;
      LOAD_W:   state_nx = (rd_ready && w_last) ? LOAD_F : LOAD_W;
      LOAD_F:   state_nx = (rd_ready && f_last) ? WAIT_PE : LOAD_F;
      WAIT_PE:  state_nx = pe_done ? NEXT_GRP : WAIT_PE;
      NEXT_GRP: state_nx = grp_last ? DONE : LOAD_W;
      default:  state_nx = IDLE;
    endcase
  end
endmodule
